// File: rtl/patchembed_sched.sv
// Patch-embedding convolution sequencer: walks every (kernel, row, col) window,
// issues credit-limited MAC requests and maps in-order results to output buffer writes.
module patchembed_sched #(
    parameter int kernels     = 64,
    parameter int out_size    = 27,
    parameter int stride      = 8,
    parameter int size        = 16,
    parameter int pixel       = 224,
    parameter int pixel_width = $clog2(pixel),
    parameter int max_out     = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic                                done,
    output logic                                busy,
    output logic                                req_valid,
    input  logic                                req_ready,
    output logic [$clog2(kernels)-1:0]          req_kernel,
    output logic [pixel_width-1:0]              req_row,
    output logic [pixel_width-1:0]              req_col,
    input  logic                                rsp_valid,
    output logic                                wr_en,
    output logic [$clog2(kernels)-1:0]          wr_kernel,
    output logic [$clog2(out_size*out_size)-1:0] wr_pos,
    output logic                                err
);
    localparam int kw = $clog2(kernels);
    localparam int cw = $clog2(out_size);
    localparam int pw = $clog2(out_size * out_size);
    localparam int ow = $clog2(max_out + 1);

    localparam logic [kw-1:0]          k_last   = kw'(kernels - 1);
    localparam logic [cw-1:0]          c_last   = cw'(out_size - 1);
    localparam logic [pw-1:0]          pos_last = pw'(out_size * out_size - 1);
    localparam logic [pixel_width-1:0] step     = pixel_width'(stride);
    localparam logic [ow-1:0]          out_max  = ow'(max_out);
    // A window geometry that does not tile the image exactly never leaves IDLE.
    localparam logic geometry_ok = ((out_size - 1) * stride + size == pixel);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state, state_next;
    logic [cw-1:0] orow, ocol;
    logic [kw-1:0] ck;
    logic [pw-1:0] cpos;
    logic [ow-1:0] outstanding;
    logic          fire, rsp_ok, launch, last_req, last_rsp;

    assign fire      = req_valid & req_ready;
    assign rsp_ok    = rsp_valid & (outstanding != '0);
    assign launch    = (state == IDLE) & start & geometry_ok;
    assign last_req  = (req_kernel == k_last) & (orow == c_last) & (ocol == c_last);
    assign last_rsp  = (ck == k_last) & (cpos == pos_last);
    assign req_valid = (state == ISSUE) & (outstanding < out_max);
    assign done      = (state == DONE);
    assign busy      = (state == ISSUE) | (state == DRAIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch)              state_next = ISSUE;
            ISSUE:   if (fire && last_req)    state_next = DRAIN;
            DRAIN:   if (rsp_ok && last_rsp)  state_next = DONE;
            DONE:    if (!start)              state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // Window origin accumulates by stride alongside the counters, so no multiplier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_kernel <= '0;
            orow       <= '0;
            ocol       <= '0;
            req_row    <= '0;
            req_col    <= '0;
        end else if (launch) begin
            req_kernel <= '0;
            orow       <= '0;
            ocol       <= '0;
            req_row    <= '0;
            req_col    <= '0;
        end else if (fire) begin
            if (ocol == c_last) begin
                ocol    <= '0;
                req_col <= '0;
                if (orow == c_last) begin
                    orow       <= '0;
                    req_row    <= '0;
                    req_kernel <= (req_kernel == k_last) ? '0 : req_kernel + 1'b1;
                end else begin
                    orow    <= orow + 1'b1;
                    req_row <= req_row + step;
                end
            end else begin
                ocol    <= ocol + 1'b1;
                req_col <= req_col + step;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  outstanding <= '0;
        else if (launch)            outstanding <= '0;
        else if (fire && !rsp_ok)   outstanding <= outstanding + 1'b1;
        else if (!fire && rsp_ok)   outstanding <= outstanding - 1'b1;
    end

    // Results come back in issue order, so a second pair of counters names each one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ck        <= '0;
            cpos      <= '0;
            wr_en     <= 1'b0;
            wr_kernel <= '0;
            wr_pos    <= '0;
        end else begin
            wr_en <= rsp_ok;
            if (launch) begin
                ck   <= '0;
                cpos <= '0;
            end else if (rsp_ok) begin
                wr_kernel <= ck;
                wr_pos    <= cpos;
                if (cpos == pos_last) begin
                    cpos <= '0;
                    ck   <= (ck == k_last) ? '0 : ck + 1'b1;
                end else begin
                    cpos <= cpos + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 err <= 1'b0;
        else if (rsp_valid && outstanding == '0)   err <= 1'b1;
        else if (launch)                           err <= 1'b0;
    end
endmodule

// File: tb/tb_patchembed_sched.sv
// Self-checking bench for patchembed_sched: small configs (max_out 4 and 2) plus the default config.
module tb_patchembed_sched;
    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    // Small config, max_out=4
    logic       a_start, a_req_ready, a_rsp_valid;
    logic       a_done, a_busy, a_req_valid, a_wr_en, a_err;
    logic [0:0] a_req_kernel, a_wr_kernel;
    logic [2:0] a_req_row, a_req_col;
    logic [3:0] a_wr_pos;

    // Small config, max_out=2
    logic       b_start, b_req_ready, b_rsp_valid;
    logic       b_done, b_busy, b_req_valid, b_wr_en, b_err;
    logic [0:0] b_req_kernel, b_wr_kernel;
    logic [2:0] b_req_row, b_req_col;
    logic [3:0] b_wr_pos;

    // Default config
    logic       c_start, c_req_ready, c_rsp_valid;
    logic       c_done, c_busy, c_req_valid, c_wr_en, c_err;
    logic [5:0] c_req_kernel, c_wr_kernel;
    logic [7:0] c_req_row, c_req_col;
    logic [9:0] c_wr_pos;

    patchembed_sched #(.kernels(2), .out_size(3), .stride(2), .size(4), .pixel(8), .max_out(4)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .done(a_done), .busy(a_busy),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_kernel(a_req_kernel),
        .req_row(a_req_row), .req_col(a_req_col), .rsp_valid(a_rsp_valid), .wr_en(a_wr_en),
        .wr_kernel(a_wr_kernel), .wr_pos(a_wr_pos), .err(a_err));

    patchembed_sched #(.kernels(2), .out_size(3), .stride(2), .size(4), .pixel(8), .max_out(2)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .done(b_done), .busy(b_busy),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_kernel(b_req_kernel),
        .req_row(b_req_row), .req_col(b_req_col), .rsp_valid(b_rsp_valid), .wr_en(b_wr_en),
        .wr_kernel(b_wr_kernel), .wr_pos(b_wr_pos), .err(b_err));

    patchembed_sched dut_c (
        .clk(clk), .reset(reset), .start(c_start), .done(c_done), .busy(c_busy),
        .req_valid(c_req_valid), .req_ready(c_req_ready), .req_kernel(c_req_kernel),
        .req_row(c_req_row), .req_col(c_req_col), .rsp_valid(c_rsp_valid), .wr_en(c_wr_en),
        .wr_kernel(c_wr_kernel), .wr_pos(c_wr_pos), .err(c_err));

    // Expected small-config order: kernel outermost, column innermost
    logic [0:0] ek[18], wk[18];
    logic [2:0] er[18], ec[18];
    logic [3:0] wp[18];

    task automatic build_model();
        int i = 0;
        for (int kk = 0; kk < 2; kk++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    ek[i] = 1'(kk);
                    er[i] = 3'(r * 2);
                    ec[i] = 3'(c * 2);
                    i++;
                end
        for (int j = 0; j < 18; j++) begin
            wk[j] = 1'(j / 9);
            wp[j] = 4'(j % 9);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_start = 0; a_req_ready = 0; a_rsp_valid = 0;
        b_start = 0; b_req_ready = 0; b_rsp_valid = 0;
        c_start = 0; c_req_ready = 0; c_rsp_valid = 0;
        #1;
        compared++;
        if ({a_done, a_busy, a_req_valid, a_wr_en, a_err, a_req_kernel, a_req_row, a_req_col,
             a_wr_kernel, a_wr_pos} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_a: got outputs %b, required all 0",
                {a_done, a_busy, a_req_valid, a_wr_en, a_err, a_req_kernel, a_req_row, a_req_col,
                 a_wr_kernel, a_wr_pos});
        end
        compared++;
        if ({c_done, c_busy, c_req_valid, c_wr_en, c_err, c_req_kernel, c_req_row, c_req_col,
             c_wr_kernel, c_wr_pos} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_c: got nonzero outputs, required all 0");
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sequence();
        int due[$];
        int cyc = 0, ridx = 0, widx = 0, first_fire = -1, last_fire = -1, last_rsp = -1, done_cyc = -1;
        a_start = 1; a_req_ready = 1; a_rsp_valid = 0;
        while (cyc < 200) begin
            @(negedge clk); cyc++;
            if (cyc == 1) begin
                compared++;
                if (a_req_valid !== 1'b1 || a_busy !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL first_valid: got valid=%b busy=%b, required 1 1", a_req_valid, a_busy);
                end
            end
            if (a_wr_en === 1'b1) begin
                compared++;
                if (widx >= 18 || a_wr_kernel !== wk[widx] || a_wr_pos !== wp[widx]) begin
                    mismatched++;
                    $display("[TB] FAIL seq_write %0d: got k=%0d pos=%0d", widx, a_wr_kernel, a_wr_pos);
                end
                widx++;
            end
            if (a_done === 1'b1) begin
                done_cyc = cyc;
                compared++;
                if (a_wr_en !== 1'b1 || widx != 18 || cyc != last_rsp + 1) begin
                    mismatched++;
                    $display("[TB] FAIL seq_done_timing: got wr_en=%b writes=%0d cyc=%0d, required 1 18 %0d",
                        a_wr_en, widx, cyc, last_rsp + 1);
                end
                break;
            end
            a_rsp_valid = (due.size() > 0 && due[0] == cyc);
            if (a_rsp_valid) begin
                void'(due.pop_front());
                last_rsp = cyc;
            end
            if (a_req_valid === 1'b1) begin
                compared++;
                if (ridx >= 18 || a_req_kernel !== ek[ridx] || a_req_row !== er[ridx] || a_req_col !== ec[ridx]) begin
                    mismatched++;
                    $display("[TB] FAIL seq_req %0d: got (%0d,%0d,%0d)", ridx, a_req_kernel, a_req_row, a_req_col);
                end
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
                ridx++;
                due.push_back(cyc + 1);
            end
        end
        a_rsp_valid = 0;
        compared++;
        if (done_cyc < 0 || ridx != 18 || widx != 18) begin
            mismatched++;
            $display("[TB] FAIL seq_counts: got req=%0d wr=%0d done_cyc=%0d, required 18 18 >0", ridx, widx, done_cyc);
        end
        compared++;
        if (last_fire - first_fire != 17) begin
            mismatched++;
            $display("[TB] FAIL seq_throughput: got span %0d, required 17", last_fire - first_fire);
        end
        @(negedge clk);
        compared++;
        if (a_done !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL seq_done_hold: got done=%b, required 1", a_done);
        end
        a_start = 0;
        @(negedge clk);
        compared++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL seq_idle: got done=%b busy=%b, required 0 0", a_done, a_busy);
        end
    endtask

    task automatic test_backpressure();
        int due[$];
        int cyc = 0, ridx = 0, widx = 0, last_rsp = -1, done_cyc = -1, d;
        bit prev_stall = 0;
        logic [0:0] sk;
        logic [2:0] sr, sc;
        a_start = 1; a_req_ready = 0; a_rsp_valid = 0;
        while (cyc < 500) begin
            @(negedge clk); cyc++;
            if (a_wr_en === 1'b1) begin
                compared++;
                if (widx >= 18 || a_wr_kernel !== wk[widx] || a_wr_pos !== wp[widx]) begin
                    mismatched++;
                    $display("[TB] FAIL bp_write %0d: got k=%0d pos=%0d", widx, a_wr_kernel, a_wr_pos);
                end
                widx++;
            end
            if (a_done === 1'b1) begin
                done_cyc = cyc;
                compared++;
                if (a_wr_en !== 1'b1 || cyc != last_rsp + 1) begin
                    mismatched++;
                    $display("[TB] FAIL bp_done_timing: got wr_en=%b cyc=%0d, required 1 %0d", a_wr_en, cyc, last_rsp + 1);
                end
                break;
            end
            if (prev_stall) begin
                compared++;
                if (a_req_valid !== 1'b1 || a_req_kernel !== sk || a_req_row !== sr || a_req_col !== sc) begin
                    mismatched++;
                    $display("[TB] FAIL bp_stable: got v=%b (%0d,%0d,%0d), required 1 (%0d,%0d,%0d)",
                        a_req_valid, a_req_kernel, a_req_row, a_req_col, sk, sr, sc);
                end
            end
            a_rsp_valid = (due.size() > 0 && due[0] == cyc);
            if (a_rsp_valid) begin
                void'(due.pop_front());
                last_rsp = cyc;
            end
            a_req_ready = 1'($urandom_range(0, 1));
            if (a_req_valid === 1'b1 && a_req_ready) begin
                compared++;
                if (ridx >= 18 || a_req_kernel !== ek[ridx] || a_req_row !== er[ridx] || a_req_col !== ec[ridx]) begin
                    mismatched++;
                    $display("[TB] FAIL bp_req %0d: got (%0d,%0d,%0d)", ridx, a_req_kernel, a_req_row, a_req_col);
                end
                ridx++;
                d = cyc + int'($urandom_range(1, 3));
                if (due.size() > 0 && d <= due[$]) d = due[$] + 1;
                due.push_back(d);
            end
            prev_stall = (a_req_valid === 1'b1) && !a_req_ready;
            sk = a_req_kernel; sr = a_req_row; sc = a_req_col;
        end
        a_rsp_valid = 0; a_req_ready = 0;
        compared++;
        if (done_cyc < 0 || ridx != 18 || widx != 18) begin
            mismatched++;
            $display("[TB] FAIL bp_counts: got req=%0d wr=%0d done_cyc=%0d, required 18 18 >0", ridx, widx, done_cyc);
        end
        a_start = 0;
        @(negedge clk);
    endtask

    task automatic test_credit();
        int due[$];
        int cyc = 0, fires = 0, outm = 0, widx = 0, done_cyc = -1;
        bit exp_valid;
        b_start = 1; b_req_ready = 1; b_rsp_valid = 0;
        while (cyc < 300) begin
            @(negedge clk); cyc++;
            if (b_wr_en === 1'b1) begin
                compared++;
                if (widx >= 18 || b_wr_kernel !== wk[widx] || b_wr_pos !== wp[widx]) begin
                    mismatched++;
                    $display("[TB] FAIL credit_write %0d: got k=%0d pos=%0d", widx, b_wr_kernel, b_wr_pos);
                end
                widx++;
            end
            if (b_done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            exp_valid = (fires < 18) && (outm < 2);
            compared++;
            if (b_req_valid !== exp_valid) begin
                mismatched++;
                $display("[TB] FAIL credit_valid cyc %0d: got %b, required %b (outstanding %0d)", cyc, b_req_valid, exp_valid, outm);
            end
            b_rsp_valid = (due.size() > 0 && due[0] == cyc);
            if (b_rsp_valid) begin
                void'(due.pop_front());
                outm--;
            end
            if (b_req_valid === 1'b1) begin
                compared++;
                if (fires >= 18 || b_req_kernel !== ek[fires] || b_req_row !== er[fires] || b_req_col !== ec[fires]) begin
                    mismatched++;
                    $display("[TB] FAIL credit_req %0d: got (%0d,%0d,%0d)", fires, b_req_kernel, b_req_row, b_req_col);
                end
                fires++;
                outm++;
                due.push_back(cyc + 5);
            end
            if (outm > 2) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL credit_inflight: got %0d in flight, required at most 2", outm);
            end
        end
        b_rsp_valid = 0;
        compared++;
        if (done_cyc < 0 || fires != 18 || widx != 18) begin
            mismatched++;
            $display("[TB] FAIL credit_counts: got req=%0d wr=%0d done_cyc=%0d, required 18 18 >0", fires, widx, done_cyc);
        end
        b_start = 0;
        @(negedge clk);
    endtask

    task automatic test_spurious();
        a_start = 0; a_req_ready = 0;
        a_rsp_valid = 1;
        @(negedge clk);
        a_rsp_valid = 0;
        @(negedge clk);
        compared++;
        if (a_err !== 1'b1 || a_wr_en !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL spurious_err: got err=%b wr_en=%b, required 1 0", a_err, a_wr_en);
        end
        @(negedge clk);
        compared++;
        if (a_err !== 1'b1 || a_busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL spurious_sticky: got err=%b busy=%b, required 1 0", a_err, a_busy);
        end
        a_start = 1;
        @(negedge clk);
        compared++;
        if (a_err !== 1'b0 || a_busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL spurious_clear: got err=%b busy=%b, required 0 1", a_err, a_busy);
        end
    endtask

    task automatic test_reset_midrun();
        int fires = 0, guard = 0;
        bit pend = 0;
        a_req_ready = 1;
        while (fires < 7 && guard < 50) begin
            @(negedge clk); guard++;
            a_rsp_valid = pend; pend = 0;
            if (a_req_valid === 1'b1) begin
                fires++;
                pend = 1;
            end
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        compared++;
        if ({a_done, a_busy, a_req_valid, a_wr_en, a_err, a_req_kernel, a_req_row, a_req_col,
             a_wr_kernel, a_wr_pos} !== '0 || fires != 7) begin
            mismatched++;
            $display("[TB] FAIL midrun_reset: got fires=%0d outputs %b, required 7 and all 0", fires,
                {a_done, a_busy, a_req_valid, a_wr_en, a_err, a_req_kernel, a_req_row, a_req_col,
                 a_wr_kernel, a_wr_pos});
        end
        a_rsp_valid = 0; a_start = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            compared++;
            if (a_wr_en !== 1'b0 || a_busy !== 1'b0 || a_req_valid !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL midrun_quiet: got wr_en=%b busy=%b valid=%b, required 0 0 0", a_wr_en, a_busy, a_req_valid);
            end
        end
        a_start = 1;
        @(negedge clk);
        compared++;
        if (a_req_valid !== 1'b1 || a_req_kernel !== ek[0] || a_req_row !== er[0] || a_req_col !== ec[0]) begin
            mismatched++;
            $display("[TB] FAIL midrun_restart0: got v=%b (%0d,%0d,%0d), required 1 (0,0,0)",
                a_req_valid, a_req_kernel, a_req_row, a_req_col);
        end
        @(negedge clk);
        compared++;
        if (a_req_valid !== 1'b1 || a_req_kernel !== ek[1] || a_req_row !== er[1] || a_req_col !== ec[1]) begin
            mismatched++;
            $display("[TB] FAIL midrun_restart1: got v=%b (%0d,%0d,%0d), required 1 (0,0,2)",
                a_req_valid, a_req_kernel, a_req_row, a_req_col);
        end
        a_start = 0; a_req_ready = 0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_run();
        int cyc = 0, ridx = 0, widx = 0, done_cyc = -1;
        bit pend = 0, done_wr = 0;
        logic [5:0] last_k = '0;
        logic [9:0] last_p = '0;
        c_start = 1; c_req_ready = 1; c_rsp_valid = 0;
        while (cyc < 47000) begin
            @(negedge clk); cyc++;
            if (c_wr_en === 1'b1) begin
                compared++;
                if (c_wr_kernel !== 6'(widx / 729) || c_wr_pos !== 10'(widx % 729)) begin
                    mismatched++;
                    $display("[TB] FAIL full_write %0d: got k=%0d pos=%0d, required %0d %0d",
                        widx, c_wr_kernel, c_wr_pos, widx / 729, widx % 729);
                end
                last_k = c_wr_kernel; last_p = c_wr_pos;
                widx++;
            end
            if (c_done === 1'b1) begin
                done_cyc = cyc;
                done_wr = c_wr_en;
                break;
            end
            c_rsp_valid = pend; pend = 0;
            if (c_req_valid === 1'b1) begin
                compared++;
                if (c_req_kernel !== 6'(ridx / 729) || c_req_row !== 8'(((ridx % 729) / 27) * 8) ||
                    c_req_col !== 8'((ridx % 27) * 8)) begin
                    mismatched++;
                    $display("[TB] FAIL full_req %0d: got (%0d,%0d,%0d)", ridx, c_req_kernel, c_req_row, c_req_col);
                end
                ridx++;
                pend = 1;
            end
        end
        c_rsp_valid = 0;
        compared++;
        if (done_cyc < 0 || widx != 46656 || ridx != 46656 || done_wr !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL full_counts: got wr=%0d req=%0d done_cyc=%0d done_wr=%b, required 46656 46656 >0 1",
                widx, ridx, done_cyc, done_wr);
        end
        compared++;
        if (last_k !== 6'd63 || last_p !== 10'd728) begin
            mismatched++;
            $display("[TB] FAIL full_last: got k=%0d pos=%0d, required 63 728", last_k, last_p);
        end
        repeat (3) begin
            @(negedge clk);
            compared++;
            if (c_done !== 1'b1 || c_wr_en !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL full_done_hold: got done=%b wr_en=%b, required 1 0", c_done, c_wr_en);
            end
        end
        c_start = 0;
        @(negedge clk);
        compared++;
        if (c_done !== 1'b0 || c_busy !== 1'b0 || c_req_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL full_idle: got done=%b busy=%b valid=%b, required 0 0 0", c_done, c_busy, c_req_valid);
        end
    endtask

    initial begin
        build_model();
        test_reset();
        test_sequence();
        test_backpressure();
        test_credit();
        test_spurious();
        test_reset_midrun();
        test_full_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/patchembed_sched.md
# patchembed_sched

Sequencer for the patch-embedding convolution. After `start`, it walks every (kernel, output row, output column) triple of the stride-`stride`, `size`×`size` convolution over the `pixel`×`pixel` image. For each triple it issues one window request to the MAC datapath over a valid/ready handshake and caps the number of in-flight requests with a credit counter. It turns each in-order MAC result into a write address for the output buffer, and raises `done` after the last result is written. It sits between the top-level start/done control and the patchembed MAC array and output memory.

## Interface
- `kernels`, 64, number of output channels / kernels
- `out_size`, 27, output map side; must satisfy (out_size-1)*stride+size == pixel
- `stride`, 8, window step in pixels
- `size`, 16, window side in pixels
- `pixel`, 224, input image side
- `pixel_width`, $clog2(pixel), pixel coordinate width
- `max_out`, 4, maximum outstanding requests, ≥1
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  level; sampled only in IDLE
- `done`  out  1  high in DONE
- `busy`  out  1  high in ISSUE and DRAIN
- `req_valid`  out  1  window request valid
- `req_ready`  in  1  datapath accepts request
- `req_kernel`  out  $clog2(kernels)  kernel index of request
- `req_row`  out  pixel_width  top-left row of window (orow*stride)
- `req_col`  out  pixel_width  top-left column of window (ocol*stride)
- `rsp_valid`  in  1  one MAC result complete (results return in issue order)
- `wr_en`  out  1  write output buffer
- `wr_kernel`  out  $clog2(kernels)  output channel of write
- `wr_pos`  out  $clog2(out_size*out_size)  orow*out_size+ocol
- `err`  out  1  sticky: rsp_valid seen with zero outstanding

## Operation
- States:
  - IDLE → ISSUE when start=1.
  - ISSUE → DRAIN on the cycle the last request fires.
  - DRAIN → DONE on the cycle the last response is accepted.
  - DONE → IDLE when start=0.
- Issue order: kernel outermost, then output row, then output column innermost. Issue counters (k, orow, ocol) advance only on a request fire (req_valid & req_ready).
- ocol wraps out_size-1→0 and carries into orow; orow wraps and carries into k.
- req_row and req_col are registered products of the counters and are updated with them. No multiply on the output path: accumulate by stride.
- Outstanding count:
  - +1 on fire, -1 on rsp_valid; both in the same cycle → unchanged.
  - Never exceeds max_out.
- req_valid = (state==ISSUE) & (outstanding<max_out). It depends only on registers. It does not wait for a same-cycle rsp_valid.
- Request fields hold stable while req_valid=1 and req_ready=0.
- Completion counters (ck, cpos) advance on each accepted rsp_valid. cpos wraps out_size²-1→0 and carries into ck.
- rsp_valid with outstanding==0:
  - Ignored: no write, no counter change.
  - Sets err. err is cleared only by reset or by the IDLE→ISSUE transition.
- Total requests = total responses = kernels*out_size². For the defaults this is 64*729 = 46656.
- start dropping during ISSUE/DRAIN is ignored; the run completes.
- start held high in DONE keeps done=1. A new run needs start low for ≥1 cycle.
- All counters clear on IDLE→ISSUE.

## Timing
- Reset values:
  - state=IDLE
  - done=0, busy=0, req_valid=0, wr_en=0, err=0
  - req_kernel, req_row, req_col, wr_kernel, wr_pos all 0
  - outstanding=0
- start sampled high at edge N → ISSUE from N+1; req_valid=1 in cycle N+1 if max_out≥1. First request is (0,0,0).
- With req_ready tied high and responses returned 1 cycle after acceptance, one request fires per cycle (max_out≥2).
- wr_en, wr_kernel, wr_pos are registered: asserted the cycle after the rsp_valid edge, for exactly one cycle per response.
- DONE is entered on the edge that accepts the last response. done rises in the same cycle the final wr_en is high.
- Asynchronous reset mid-run: all outputs go to reset values immediately, with no trailing write. Restart requires a new start.

## Test plan
- Small config (kernels=2, out_size=3, stride=2, size=4, pixel=8), req_ready=1, rsp 1 cycle after fire, max_out=4:
  - Required: 18 requests issued.
  - Sequence: (0,0,0), (0,0,2), (0,0,4), (0,2,0), … (1,4,4).
  - Required: 18 writes with wr_pos 0..8 for kernel 0, then 0..8 for kernel 1.
  - Required: done one cycle after the last rsp_valid, i.e. with the final wr_en.
- Backpressure: req_ready toggling pseudo-randomly. Required: fields stable during stalls, no skipped or duplicate request, identical write sequence.
- Credit limit, max_out=2, responses delayed 5 cycles:
  - Required: req_valid drops after 2 outstanding and never 3 in flight.
  - Required: a simultaneous fire+rsp keeps outstanding at 2.
- Spurious rsp_valid in IDLE. Required: err=1, no wr_en; err clears when the next run starts.
- Reset asserted mid-ISSUE after 7 fires. Required: all outputs 0 immediately; the next start reissues from (0,0,0).
- Default config, start held until done then dropped:
  - Required: 46656 writes; the last is wr_kernel=63, wr_pos=728.
  - Required: state returns to IDLE one cycle after start=0.
